// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage: bus layouts, stall vector, ALU op indices.
// Pure declarations; no logic, so no latency or backpressure of its own.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 164;
    localparam int EX_TO_MEM_WD = 81;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int EX_IDX  = 2;
    localparam int MEM_IDX = 3;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

    typedef logic [STALL_BUS-1:0] stall_bus_t;

    typedef struct packed {
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_div_inst(input logic [31:0] inst);
        return (inst[31:26] == 6'd0) &&
               ((inst[5:0] == FUNCT_DIV) || (inst[5:0] == FUNCT_DIVU));
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Data SRAM request port driven by the execute stage.
// Combinational request, no handshake: the SRAM accepts every cycle.
interface ex_stage_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
    modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider owning HI/LO; latency DIV_ITER+1 cycles (1 for divide-by-zero).
// Holds DONE until ack; cancel returns to IDLE without touching HI/LO.
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    input  logic        ack,
    output logic        ready,
    output hilo_t       result
);

    localparam int CW = $clog2(DIV_ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   rem, quo, dvs;
    logic          neg_q, neg_r;
    logic [31:0]   a_abs, b_abs;
    logic [32:0]   diff;
    logic          ge;
    logic [31:0]   rem_nx, quo_nx, q_fix, r_fix;

    assign a_abs = (signed_op && opa[31]) ? -opa : opa;
    assign b_abs = (signed_op && opb[31]) ? -opb : opb;

    // rem < dvs always holds, so a 33-bit difference suffices and bit 32 is the borrow
    assign diff   = {rem, quo[31]} - {1'b0, dvs};
    assign ge     = ~diff[32];
    assign rem_nx = ge ? diff[31:0] : {rem[30:0], quo[31]};
    assign quo_nx = {quo[30:0], ge};
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
        end else if (cancel) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (opb == 32'd0) begin
                            state     <= S_DONE;
                            result.hi <= opa;
                            result.lo <= '1;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= '0;
                            rem   <= '0;
                            quo   <= a_abs;
                            dvs   <= b_abs;
                            neg_q <= signed_op & (opa[31] ^ opb[31]);
                            neg_r <= signed_op & opa[31];
                        end
                    end
                end
                S_BUSY: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIV_ITER - 1)) begin
                        state     <= S_DONE;
                        result.hi <= r_fix;
                        result.lo <= q_fix;
                    end
                end
                S_DONE: begin
                    if (ack) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_DONE);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, ALU, data SRAM request, forwarding, divider with HI/LO.
// Results one cycle after capture; requests a pipeline stall while a divide is unfinished.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  stall_bus_t              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    ex_stage_if.master              sram,
    output logic                    ex_we,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_ram_read,
    output logic                    stallreq_for_ex,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o
);

    id_ex_t      ex_q;
    logic [31:0] src1, src2, imm_sext, imm_zext, alu_res;
    logic        is_div, div_ready;
    hilo_t       hilo;
    ex_mem_t     mem_bus;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_q <= '0;
        end else if (stall[EX_IDX] == STOP && stall[MEM_IDX] == NO_STOP) begin
            ex_q <= '0;
        end else if (stall[EX_IDX] == NO_STOP) begin
            ex_q <= id_to_ex_bus;
        end
    end

    assign imm_sext = {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    assign imm_zext = {16'd0, ex_q.inst[15:0]};

    // selects are one-hot from decode, so an AND-OR mux is sufficient
    assign src1 = ({32{ex_q.sel_alu_src1[0]}} & ex_q.rdata1)
                | ({32{ex_q.sel_alu_src1[1]}} & ex_q.pc)
                | ({32{ex_q.sel_alu_src1[2]}} & {27'd0, ex_q.inst[10:6]});
    assign src2 = ({32{ex_q.sel_alu_src2[0]}} & ex_q.rdata2)
                | ({32{ex_q.sel_alu_src2[1]}} & imm_sext)
                | ({32{ex_q.sel_alu_src2[2]}} & 32'd8)
                | ({32{ex_q.sel_alu_src2[3]}} & imm_zext);

    always_comb begin
        alu_res = '0;
        if      (ex_q.alu_op[ALU_ADD])  alu_res = src1 + src2;
        else if (ex_q.alu_op[ALU_SUB])  alu_res = src1 - src2;
        else if (ex_q.alu_op[ALU_SLT])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
        else if (ex_q.alu_op[ALU_SLTU]) alu_res = {31'd0, src1 < src2};
        else if (ex_q.alu_op[ALU_AND])  alu_res = src1 & src2;
        else if (ex_q.alu_op[ALU_NOR])  alu_res = ~(src1 | src2);
        else if (ex_q.alu_op[ALU_OR])   alu_res = src1 | src2;
        else if (ex_q.alu_op[ALU_XOR])  alu_res = src1 ^ src2;
        else if (ex_q.alu_op[ALU_SLL])  alu_res = src2 << src1[4:0];
        else if (ex_q.alu_op[ALU_SRL])  alu_res = src2 >> src1[4:0];
        else if (ex_q.alu_op[ALU_SRA])  alu_res = $signed(src2) >>> src1[4:0];
        else if (ex_q.alu_op[ALU_LUI])  alu_res = {src2[15:0], 16'd0};
    end

    assign is_div = is_div_inst(ex_q.inst);

    div_unit #(.DIV_ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_op (ex_q.inst[5:0] == FUNCT_DIV),
        .opa       (ex_q.rdata1),
        .opb       (ex_q.rdata2),
        .cancel    (flush),
        .ack       (stall[MEM_IDX] == NO_STOP),
        .ready     (div_ready),
        .result    (hilo)
    );

    assign stallreq_for_ex = is_div & ~div_ready;
    assign hi_o = hilo.hi;
    assign lo_o = hilo.lo;

    assign mem_bus = '{mem_op:       ex_q.mem_op,
                       pc:           ex_q.pc,
                       data_ram_en:  ex_q.data_ram_en,
                       data_ram_wen: ex_q.data_ram_wen,
                       sel_rf_res:   ex_q.sel_rf_res,
                       rf_we:        ex_q.rf_we,
                       rf_waddr:     ex_q.rf_waddr,
                       ex_result:    alu_res};
    assign ex_to_mem_bus = mem_bus;

    assign sram.data_sram_en    = ex_q.data_ram_en;
    assign sram.data_sram_wen   = {4{ex_q.data_ram_wen[0]}};
    assign sram.data_sram_addr  = alu_res;
    assign sram.data_sram_wdata = ex_q.rdata2;

    assign ex_we       = ex_q.rf_we;
    assign ex_waddr    = ex_q.rf_waddr;
    assign ex_wdata    = alu_res;
    assign ex_ram_read = ex_q.data_ram_en & ex_q.sel_rf_res;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], ex_q.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: the driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst, flush;
    logic [5:0]              stall_force;
    stall_bus_t              stall;
    logic [ID_TO_EX_WD-1:0]  id_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic                    ex_we, ex_ram_read, stallreq_for_ex;
    logic [4:0]              ex_waddr;
    logic [31:0]             ex_wdata, hi_o, lo_o;

    ex_stage_if sram_if();

    ex_stage #(.DIV_ITER(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .sram            (sram_if),
        .ex_we           (ex_we),
        .ex_waddr        (ex_waddr),
        .ex_wdata        (ex_wdata),
        .ex_ram_read     (ex_ram_read),
        .stallreq_for_ex (stallreq_for_ex),
        .hi_o            (hi_o),
        .lo_o            (lo_o)
    );

    always #5 clk = ~clk;

    // a simple hazard unit: a stalled execute freezes IF/ID/EX and holds MEM
    assign stall = stall_force | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    typedef struct packed {
        logic [80:0] bus;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wd;
        logic        rr;
        logic        sr;
        logic [31:0] hi;
        logic [31:0] lo;
    } obs_t;

    obs_t dut_obs;
    assign dut_obs = {ex_to_mem_bus, sram_if.data_sram_en, sram_if.data_sram_wen,
                      sram_if.data_sram_addr, sram_if.data_sram_wdata, ex_we, ex_waddr,
                      ex_wdata, ex_ram_read, stallreq_for_ex, hi_o, lo_o};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    cyc_q[$];
    obs_t  exp_q[$];
    string nm_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  end_chk = 1'b0;
    logic  end_done = 1'b0;

    id_ex_t      m_reg;
    logic [31:0] m_hi, m_lo;

    function automatic logic [31:0] ref_alu(input id_ex_t r);
        logic [31:0] a, b;
        logic [4:0]  sh;
        a = r.sel_alu_src1[0] ? r.rdata1 :
            r.sel_alu_src1[1] ? r.pc :
            r.sel_alu_src1[2] ? {27'd0, r.inst[10:6]} : 32'd0;
        b = r.sel_alu_src2[0] ? r.rdata2 :
            r.sel_alu_src2[1] ? {{16{r.inst[15]}}, r.inst[15:0]} :
            r.sel_alu_src2[2] ? 32'd8 :
            r.sel_alu_src2[3] ? {16'd0, r.inst[15:0]} : 32'd0;
        sh = a[4:0];
        case (r.alu_op)
            12'h800: return a + b;
            12'h400: return a - b;
            12'h200: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            12'h100: return (a < b) ? 32'd1 : 32'd0;
            12'h080: return a & b;
            12'h040: return ~(a | b);
            12'h020: return a | b;
            12'h010: return a ^ b;
            12'h008: return b << sh;
            12'h004: return b >> sh;
            12'h002: return $signed(b) >>> sh;
            12'h001: return {b[15:0], 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic obs_t exp_obs(input id_ex_t r, input logic [31:0] hi, input logic [31:0] lo,
                                     input logic sr);
        obs_t        o;
        logic [31:0] res;
        res     = ref_alu(r);
        o.bus   = {r.mem_op, r.pc, r.data_ram_en, r.data_ram_wen, r.sel_rf_res, r.rf_we,
                   r.rf_waddr, res};
        o.en    = r.data_ram_en;
        o.wen   = r.data_ram_wen[0] ? 4'hF : 4'h0;
        o.addr  = res;
        o.wdata = r.rdata2;
        o.we    = r.rf_we;
        o.waddr = r.rf_waddr;
        o.wd    = res;
        o.rr    = r.data_ram_en & r.sel_rf_res;
        o.sr    = sr;
        o.hi    = hi;
        o.lo    = lo;
        return o;
    endfunction

    task automatic push(input int c, input obs_t e, input string nm);
        cyc_q.push_back(c);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            int    c;
            obs_t  e;
            string nm;
            c  = cyc_q.pop_front();
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (c < cyc) begin
                n_errors++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", nm, c, cyc);
            end else if (dut_obs !== e) begin
                n_errors++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, dut_obs, e);
            end
        end
        if (end_chk && !end_done) begin
            end_done <= 1'b1;
            n_checks++;
            if (cyc_q.size() != 0) begin
                n_errors++;
                $display("FAIL drain got=%0d pending exp=0", cyc_q.size());
            end
        end
    end

    task automatic issue(input id_ex_t r, input string nm);
        @(posedge clk); #1;
        stall_force = 6'b0;
        id_bus      = r;
        m_reg       = r;
        push(cyc + 1, exp_obs(r, m_hi, m_lo, 1'b0), nm);
    endtask

    task automatic bubble(input id_ex_t junk, input string nm);
        @(posedge clk); #1;
        id_bus      = junk;
        stall_force = 6'b000100;
        m_reg       = '0;
        push(cyc + 1, exp_obs('0, m_hi, m_lo, 1'b0), nm);
    endtask

    task automatic hold(input id_ex_t junk, input string nm);
        @(posedge clk); #1;
        id_bus      = junk;
        stall_force = 6'b001100;
        push(cyc + 1, exp_obs(m_reg, m_hi, m_lo, 1'b0), nm);
    endtask

    function automatic id_ex_t mk_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        id_ex_t r;
        r        = '0;
        r.pc     = 32'hBFC0_0100;
        r.inst   = {6'd0, 5'd4, 5'd5, 10'd0, sgn ? FUNCT_DIV : FUNCT_DIVU};
        r.rdata1 = a;
        r.rdata2 = b;
        return r;
    endfunction

    // abort_at < 0: run to completion; otherwise flush (or rst) during cycle abort_at-1 of the divide
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input logic use_rst, input string nm);
        id_ex_t             r;
        int                 c0, s;
        logic [31:0]        hi_n, lo_n;
        logic signed [31:0] sa, sb;
        r  = mk_div(sgn, a, b);
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            hi_n = a;
            lo_n = 32'hFFFF_FFFF;
        end else if (sgn) begin
            lo_n = sa / sb;
            hi_n = sa % sb;
        end else begin
            lo_n = a / b;
            hi_n = a % b;
        end
        s = (b == 32'd0) ? 1 : 33;
        @(posedge clk); #1;
        stall_force = 6'b0;
        id_bus      = r;
        c0          = cyc + 1;
        if (abort_at < 0) begin
            for (int k = 0; k < s; k++) push(c0 + k, exp_obs(r, m_hi, m_lo, 1'b1), nm);
            m_hi = hi_n;
            m_lo = lo_n;
            push(c0 + s, exp_obs(r, m_hi, m_lo, 1'b0), {nm, "_done"});
            @(posedge clk); #1;
            id_bus = '0;
            repeat (s - 1) @(posedge clk);
        end else begin
            for (int k = 0; k < abort_at; k++) push(c0 + k, exp_obs(r, m_hi, m_lo, 1'b1), nm);
            @(posedge clk); #1;
            id_bus = '0;
            repeat (abort_at - 1) @(posedge clk);
            #1;
            if (use_rst) begin
                rst  = 1'b1;
                m_hi = '0;
                m_lo = '0;
            end else begin
                flush = 1'b1;
            end
            push(c0 + abort_at, exp_obs('0, m_hi, m_lo, 1'b0), {nm, "_abort"});
            @(posedge clk); #1;
            rst   = 1'b0;
            flush = 1'b0;
        end
        m_reg = '0;
    endtask

    function automatic id_ex_t rand_alu();
        id_ex_t r;
        int     k;
        r.mem_op       = 5'($urandom_range(0, 31));
        r.pc           = $urandom();
        r.inst         = $urandom();
        if (r.inst[31:26] == 6'd0) r.inst[31:26] = 6'd9;
        k              = $urandom_range(0, 12);
        r.alu_op       = (k == 12) ? 12'h000 : (12'h001 << k);
        r.sel_alu_src1 = 3'b001 << $urandom_range(0, 2);
        r.sel_alu_src2 = 4'b0001 << $urandom_range(0, 3);
        r.data_ram_en  = 1'($urandom_range(0, 1));
        r.data_ram_wen = 4'($urandom_range(0, 15));
        r.rf_we        = 1'($urandom_range(0, 1));
        r.rf_waddr     = 5'($urandom_range(0, 31));
        r.sel_rf_res   = 1'($urandom_range(0, 1));
        r.rdata1       = $urandom();
        r.rdata2       = $urandom();
        return r;
    endfunction

    initial begin
        id_ex_t      addu_r, sw_r, lw_r, lui_r;
        logic [31:0] a, b;
        logic        sg;

        rst         = 1'b1;
        flush       = 1'b0;
        stall_force = 6'b0;
        id_bus      = '0;
        m_reg       = '0;
        m_hi        = '0;
        m_lo        = '0;
        repeat (3) @(posedge clk);
        #1;
        push(cyc, exp_obs('0, 32'd0, 32'd0, 1'b0), "reset");
        @(posedge clk); #1;
        rst = 1'b0;

        addu_r              = '0;
        addu_r.pc           = 32'hBFC0_0000;
        addu_r.inst         = {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'b100001};
        addu_r.alu_op       = 12'h800;
        addu_r.sel_alu_src1 = 3'b001;
        addu_r.sel_alu_src2 = 4'b0001;
        addu_r.rf_we        = 1'b1;
        addu_r.rf_waddr     = 5'd9;
        addu_r.rdata1       = 32'h7FFF_FFFF;
        addu_r.rdata2       = 32'd1;
        issue(addu_r, "addu_wrap");

        sw_r              = '0;
        sw_r.pc           = 32'hBFC0_0004;
        sw_r.inst         = {6'b101011, 5'd3, 5'd6, 16'hFFFC};
        sw_r.alu_op       = 12'h800;
        sw_r.sel_alu_src1 = 3'b001;
        sw_r.sel_alu_src2 = 4'b0010;
        sw_r.data_ram_en  = 1'b1;
        sw_r.data_ram_wen = 4'hF;
        sw_r.rdata1       = 32'h0000_1000;
        sw_r.rdata2       = 32'hDEAD_BEEF;
        issue(sw_r, "sw");

        lw_r              = '0;
        lw_r.mem_op       = 5'b00010;
        lw_r.pc           = 32'hBFC0_0008;
        lw_r.inst         = {6'b100011, 5'd3, 5'd5, 16'h0008};
        lw_r.alu_op       = 12'h800;
        lw_r.sel_alu_src1 = 3'b001;
        lw_r.sel_alu_src2 = 4'b0010;
        lw_r.data_ram_en  = 1'b1;
        lw_r.rf_we        = 1'b1;
        lw_r.rf_waddr     = 5'd5;
        lw_r.sel_rf_res   = 1'b1;
        lw_r.rdata1       = 32'h0000_2000;
        issue(lw_r, "lw");
        bubble(addu_r, "lw_bubble");
        issue(lw_r, "lw_again");
        hold(addu_r, "lw_hold");

        lui_r              = '0;
        lui_r.inst         = {6'b001111, 5'd0, 5'd7, 16'h1234};
        lui_r.alu_op       = 12'h001;
        lui_r.sel_alu_src2 = 4'b1000;
        lui_r.rf_we        = 1'b1;
        lui_r.rf_waddr     = 5'd7;
        issue(lui_r, "lui");

        do_div(1'b0, 32'd100, 32'd7, -1, 1'b0, "divu_100_7");
        issue(addu_r, "after_divu");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_m7_2");
        do_div(1'b1, 32'h1234_5678, 32'd0, -1, 1'b0, "div_by_zero");
        issue(sw_r, "after_div0");
        do_div(1'b0, 32'd1000, 32'd3, 10, 1'b0, "divu_flush");
        issue(addu_r, "after_flush");
        do_div(1'b0, 32'd55, 32'd5, 5, 1'b1, "divu_rst");
        issue(addu_r, "after_rst");

        for (int i = 0; i < 40; i++) issue(rand_alu(), $sformatf("rand_alu%0d", i));

        for (int i = 0; i < 8; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom();
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 31));
            if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            do_div(sg, a, b, -1, 1'b0, $sformatf("rand_div%0d", i));
            issue(rand_alu(), $sformatf("rand_post_div%0d", i));
        end

        @(posedge clk); #1;
        stall_force = 6'b0;
        id_bus      = '0;
        repeat (3) @(posedge clk);
        end_chk = 1'b1;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline, directly downstream of instruction decode. It latches the decode-to-execute bus and evaluates the ALU result. It issues the data SRAM request for loads and stores and drives forwarding and load-use signals back to decode. It also contains a multi-cycle signed/unsigned divider that writes the HI/LO registers and stalls the pipeline while it runs.

Parameters:
ID_TO_EX_WD, 164, width of the decode-to-execute bus.
EX_TO_MEM_WD, 81, width of the execute-to-memory bus.
DIV_ITER, 32, number of radix-2 divider iterations.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
flush  in  1  pipeline flush
stall  in  StallBus (6)  per-stage stall vector, Stop=1
id_to_ex_bus  in  164  fields, MSB first: mem_op[163:159] (bit1=lw, bit0=lh), pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]
ex_to_mem_bus  out  81  fields, MSB first: {mem_op, pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
data_sram_en  out  1  data SRAM enable
data_sram_wen  out  4  data SRAM byte write enables
data_sram_addr  out  32  data SRAM address
data_sram_wdata  out  32  data SRAM write data
ex_we, ex_waddr, ex_wdata  out  1/5/32  forwarding to decode
ex_ram_read  out  1  instruction currently in execute is a load
stallreq_for_ex  out  1  divider busy; stall request
hi_o, lo_o  out  32/32  architectural HI/LO

Behaviour:
- Input register. Priority: rst, then flush, both clear it. Next, stall[2]=Stop with stall[3]=NoStop inserts a bubble (clears it). Next, stall[2]=NoStop captures id_to_ex_bus. Otherwise the register holds.
- All outputs are combinational from the input register, the divider FSM and HI/LO. After reset every output is 0, because the register is 0, the FSM is IDLE and HI/LO are 0.
- src1 selection: bit0 selects rdata1, bit1 selects pc, bit2 selects zero-extended inst[10:6]. src2 selection: bit0 selects rdata2, bit1 selects sign-extended imm, bit2 selects 32'd8, bit3 selects zero-extended imm.
- ALU op vector, MSB first: {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}. Exactly one bit is set, or none (result 0).
  - Shifts use src1[4:0] as the amount and src2 as the data; sra is arithmetic.
  - lui gives {src2[15:0], 16'b0}.
  - add and sub wrap modulo 2^32; no overflow trap.
- ex_result is the ALU result, and ex_wdata equals ex_result.
- data_sram_en = data_ram_en. data_sram_wen = 4'b1111 when data_ram_wen[0] is set, else 0. data_sram_addr = ex_result. data_sram_wdata = rdata2.
- ex_we = rf_we. ex_waddr = rf_waddr. ex_ram_read = data_ram_en & sel_rf_res.
- Divide decode: inst[31:26]=0 with inst[5:0]=011010 is div (signed); with 011011 it is divu.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY: a divide is in the register and the divisor is non-zero. Operands are latched this cycle; signed mode latches absolute values plus the sign flags.
  - BUSY: one restoring shift-subtract step per cycle for DIV_ITER cycles, then go to DONE.
  - IDLE to DONE: a divide is in the register and the divisor is 0. LO becomes 0xFFFFFFFF and HI becomes the dividend.
  - DONE: HI/LO are written exactly once, on entry. Signed fix-up: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - DONE to IDLE: when stall[3]=NoStop. DONE holds while stall[3]=Stop, and no restart occurs.
- stallreq_for_ex = divide in the register & state != DONE. It is asserted in the first cycle combinationally. For a non-zero divisor it stays high for 33 cycles, then drops for 1 cycle in DONE. For divisor 0 it stays high for 1 cycle.
- A flush or rst in BUSY or DONE sends the FSM to IDLE. HI/LO are not written unless the DONE entry has already occurred.

Decomposition:
- Shared defines header: ID_TO_EX_WD, EX_TO_MEM_WD, StallBus, Stop/NoStop, and the alu_op bit indices.
- Sub-module div_unit holds the FSM, the iteration counter, the remainder/quotient shift registers and the sign fix-up. Its interface: start, signed_op, opa, opb, cancel, ready, result{hi, lo}. The ALU and muxes stay inline in ex_stage.

Test Plan:
- addu with rdata1=0x7FFFFFFF, rdata2=1 -> ex_result=0x80000000, ex_we=1, ex_waddr=rd, stallreq_for_ex=0 throughout.
- sw with base=0x1000, imm=0xFFFC, rdata2=0xDEADBEEF -> data_sram_en=1, data_sram_wen=4'hF, data_sram_addr=0x0FFC, data_sram_wdata=0xDEADBEEF.
- lw into $5 -> ex_ram_read=1, ex_waddr=5. Next cycle with a bubble inserted -> ex_ram_read=0.
- divu 100/7 -> stallreq_for_ex high for 33 cycles, then low. lo_o=14, hi_o=2, written exactly once.
- div -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. div x/0 -> 1-cycle stall, lo_o=0xFFFFFFFF, hi_o=x.
- flush asserted at cycle 10 of a divu -> FSM IDLE, stallreq_for_ex=0 next cycle, HI/LO unchanged. rst mid-divide -> all outputs 0.
